// File: rtl/max_args_seq_pkg.sv
// Shared types and constants for the max_args search sequencer.
package max_args_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    SETTLE,
    CAPTURE,
    EVAL,
    FINISH
  } state_t;

  localparam int ST_DET = 0;
  localparam int ST_NF  = 1;
  localparam int ST_TMO = 2;

  typedef struct packed {
    logic [31:0] amp;
    logic [31:0] tau;
    logic [15:0] freq;
  } peak_t;

endpackage

// File: rtl/max_args_seq_tmo.sv
// Loadable down-counter for the per-pass timeout; expired is high while enabled at zero.
module max_args_seq_tmo #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/max_args_seq.sv
// Multi-pass sequencer for the max_args peak search: clears, runs, captures and
// keeps the best peak, then reports detect / notfound / timeout with an irq pulse.
module max_args_seq
  import max_args_seq_pkg::*;
#(
  parameter int NPASS_MAX  = 8,
  parameter int CLR_CYC    = 2,
  parameter int SETTLE_CYC = 2,
  parameter int TMO_W      = 24,
  localparam int PW        = $clog2(NPASS_MAX) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      cfg_ntau,
  input  logic [15:0]      cfg_nf,
  input  logic [PW-1:0]    cfg_npass,
  input  logic [31:0]      cfg_thr,
  input  logic [TMO_W-1:0] cfg_tmo,
  output logic             reset_max,
  output logic [15:0]      ntau,
  output logic [15:0]      nf,
  input  logic             done_max,
  input  logic [31:0]      amp_in,
  input  logic [31:0]      tau_in,
  input  logic [15:0]      freq_in,
  output logic             run,
  output logic             busy,
  output logic [31:0]      best_amp,
  output logic [31:0]      best_tau,
  output logic [15:0]      best_freq,
  output logic [PW-1:0]    best_pass,
  output logic [2:0]       status,
  output logic             irq,
  output state_t           dbg_state
);

  localparam int CW = $clog2(CLR_CYC + SETTLE_CYC + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cyc_cnt;
  logic [PW-1:0]    npass_q, npass_clamped, pass;
  logic [31:0]      thr_q;
  logic [TMO_W-1:0] tmo_q;
  peak_t            best;
  logic [2:0]       status_q;
  logic             tmo_expired, tmo_hit, start_ok, last_pass, det;

  // start and done_max are single-cycle strobes with no back-pressure: start is
  // accepted only while busy is low, done_max only while run is high.
  assign start_ok  = (state == IDLE) && start && !abort;
  assign tmo_hit   = tmo_expired && (tmo_q != '0);
  assign last_pass = (pass == npass_q - PW'(1));
  assign det       = (best.amp >= thr_q);

  always_comb begin
    npass_clamped = cfg_npass;
    if (cfg_npass == '0) begin
      npass_clamped = PW'(1);
    end else if (cfg_npass > PW'(NPASS_MAX)) begin
      npass_clamped = PW'(NPASS_MAX);
    end
  end

  max_args_seq_tmo #(.W(TMO_W)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .load     (state != RUN),
    .load_val (tmo_q - 1'b1),
    .en       (state == RUN),
    .expired  (tmo_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = CLEAR;
      CLEAR:   if (cyc_cnt == CW'(CLR_CYC - 1)) state_nxt = RUN;
      RUN: begin
        if (done_max)     state_nxt = SETTLE;
        else if (tmo_hit) state_nxt = FINISH;
      end
      SETTLE:  if (cyc_cnt == CW'(SETTLE_CYC - 1)) state_nxt = CAPTURE;
      CAPTURE: state_nxt = EVAL;
      EVAL:    state_nxt = (det || last_pass) ? FINISH : CLEAR;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Dwell counter restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
    end else if (state_nxt != state) begin
      cyc_cnt <= '0;
    end else if ((state == CLEAR) || (state == SETTLE)) begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ntau      <= '0;
      nf        <= '0;
      npass_q   <= '0;
      thr_q     <= '0;
      tmo_q     <= '0;
      pass      <= '0;
      best      <= '0;
      best_pass <= '0;
      status_q  <= '0;
    end else if (!abort) begin
      case (state)
        IDLE: if (start_ok) begin
          ntau      <= cfg_ntau;
          nf        <= cfg_nf;
          npass_q   <= npass_clamped;
          thr_q     <= cfg_thr;
          tmo_q     <= cfg_tmo;
          pass      <= '0;
          best      <= '0;
          best_pass <= '0;
          status_q  <= '0;
        end
        RUN: if (!done_max && tmo_hit) status_q[ST_TMO] <= 1'b1;
        // Strict compare so a tie keeps the earlier pass.
        CAPTURE: if (amp_in > best.amp) begin
          best      <= '{amp: amp_in, tau: tau_in, freq: freq_in};
          best_pass <= pass;
        end
        EVAL: begin
          if (det)            status_q[ST_DET] <= 1'b1;
          else if (last_pass) status_q[ST_NF]  <= 1'b1;
          else                pass             <= pass + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    reset_max = 1'b0;
    run       = 1'b0;
    irq       = 1'b0;
    case (state)
      IDLE, CLEAR: reset_max = 1'b1;
      RUN:         run       = 1'b1;
      FINISH:      irq       = !abort;
      default:     ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign best_amp  = best.amp;
  assign best_tau  = best.tau;
  assign best_freq = best.freq;
  assign status    = status_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_max_args_seq.sv
// Directed bench for max_args_seq: one task per scenario, hand-computed expectations.
module tb_max_args_seq;
  import max_args_seq_pkg::*;

  localparam int PW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, done_max = 1'b0;
  logic [15:0] cfg_ntau = '0, cfg_nf = '0;
  logic [PW-1:0] cfg_npass = '0;
  logic [31:0] cfg_thr = '0;
  logic [23:0] cfg_tmo = '0;
  logic [31:0] amp_in = '0, tau_in = '0;
  logic [15:0] freq_in = '0;
  logic        reset_max, run, busy, irq;
  logic [15:0] ntau, nf, best_freq;
  logic [31:0] best_amp, best_tau;
  logic [PW-1:0] best_pass;
  logic [2:0]  status;
  state_t      dbg_state;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  max_args_seq #(.NPASS_MAX(8), .CLR_CYC(2), .SETTLE_CYC(2), .TMO_W(24)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_ntau(cfg_ntau), .cfg_nf(cfg_nf), .cfg_npass(cfg_npass),
    .cfg_thr(cfg_thr), .cfg_tmo(cfg_tmo),
    .reset_max(reset_max), .ntau(ntau), .nf(nf),
    .done_max(done_max), .amp_in(amp_in), .tau_in(tau_in), .freq_in(freq_in),
    .run(run), .busy(busy), .best_amp(best_amp), .best_tau(best_tau),
    .best_freq(best_freq), .best_pass(best_pass), .status(status), .irq(irq),
    .dbg_state(dbg_state)
  );

  // Event counters sampled on the falling edge, compared as deltas by each test.
  int   irq_n = 0, run_n = 0, clr_n = 0, fall_n = 0;
  logic prev_rm = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      prev_rm = 1'b1;
    end else begin
      if (irq) irq_n++;
      if (run) run_n++;
      if (busy && reset_max) clr_n++;
      if (prev_rm && !reset_max) fall_n++;
      prev_rm = reset_max;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] nt, input logic [15:0] f, input logic [PW-1:0] np,
                          input logic [31:0] thr, input logic [23:0] tmo);
    cfg_ntau = nt; cfg_nf = f; cfg_npass = np; cfg_thr = thr; cfg_tmo = tmo;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (run !== 1'b1 && n < 40) begin tick(); n++; end
    total++;
    if (run !== 1'b1) begin bad++; $display("FAIL wait_run: run=%b expected 1", run); end
  endtask

  // Emulates max_args: done_max in RUN cycle len-1, so run is high for len cycles.
  task automatic do_pass(input int len, input logic [31:0] a, input logic [31:0] t, input logic [15:0] f);
    wait_run();
    repeat (len - 1) tick();
    done_max = 1'b1; amp_in = a; tau_in = t; freq_in = f;
    tick();
    done_max = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin tick(); n++; end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL wait_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++;
    if ({reset_max, run, busy, irq} !== 4'b1000) begin
      bad++; $display("FAIL reset_ctl: {rm,run,busy,irq}=%b expected 1000", {reset_max, run, busy, irq});
    end
    total++;
    if (status !== 3'b000 || best_amp !== 32'd0 || best_pass !== 4'd0 || ntau !== 16'd0 || nf !== 16'd0) begin
      bad++; $display("FAIL reset_regs: status=%b best_amp=%0d best_pass=%0d ntau=%0d nf=%0d expected all 0",
                      status, best_amp, best_pass, ntau, nf);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_detect();
    int s_irq = irq_n, s_run = run_n, lat = 0;
    cfg_ntau = 16'd1000; cfg_nf = 16'd64; cfg_npass = 4'd1; cfg_thr = 32'd100; cfg_tmo = '0;
    start = 1'b1;
    do begin tick(); lat++; start = 1'b0; end while (run !== 1'b1 && lat < 20);
    total++;
    if (lat != 3) begin bad++; $display("FAIL start_latency: got %0d expected 3", lat); end
    total++;
    if (ntau !== 16'd1000 || nf !== 16'd64) begin
      bad++; $display("FAIL cfg_latch: ntau=%0d nf=%0d expected 1000 64", ntau, nf);
    end
    do_pass(50, 32'd200, 32'd7, 16'd3);
    wait_idle(20);
    total++;
    if (status !== 3'b001) begin bad++; $display("FAIL single_status: got %b expected 001", status); end
    total++;
    if (best_amp !== 32'd200 || best_tau !== 32'd7 || best_freq !== 16'd3 || best_pass !== 4'd0) begin
      bad++; $display("FAIL single_best: got (%0d,%0d,%0d,p%0d) expected (200,7,3,p0)",
                      best_amp, best_tau, best_freq, best_pass);
    end
    total++;
    if (irq_n - s_irq != 1) begin bad++; $display("FAIL single_irq: got %0d pulses expected 1", irq_n - s_irq); end
    total++;
    if (run_n - s_run != 50) begin bad++; $display("FAIL single_run_len: got %0d expected 50", run_n - s_run); end
  endtask

  task automatic test_multi_notfound();
    int s_irq = irq_n, s_clr = clr_n, s_fall = fall_n;
    do_start(16'd10, 16'd20, 4'd3, 32'd1000, '0);
    do_pass(5, 32'd10, 32'd1, 16'd1);
    do_pass(5, 32'd40, 32'd2, 16'd2);
    do_pass(5, 32'd20, 32'd3, 16'd3);
    wait_idle(50);
    total++;
    if (status !== 3'b010) begin bad++; $display("FAIL multi_status: got %b expected 010", status); end
    total++;
    if (best_amp !== 32'd40 || best_tau !== 32'd2 || best_pass !== 4'd1) begin
      bad++; $display("FAIL multi_best: got amp=%0d tau=%0d pass=%0d expected 40 2 1", best_amp, best_tau, best_pass);
    end
    total++;
    if (fall_n - s_fall != 3 || clr_n - s_clr != 6) begin
      bad++; $display("FAIL multi_clears: got passes=%0d clr_cycles=%0d expected 3 6", fall_n - s_fall, clr_n - s_clr);
    end
    total++;
    if (irq_n - s_irq != 1) begin bad++; $display("FAIL multi_irq: got %0d expected 1", irq_n - s_irq); end
  endtask

  task automatic test_early_exit();
    int s_fall = fall_n;
    do_start(16'd10, 16'd20, 4'd4, 32'd50, '0);
    do_pass(5, 32'd30, 32'd5, 16'd5);
    do_pass(5, 32'd60, 32'd6, 16'd6);
    wait_idle(30);
    total++;
    if (status !== 3'b001 || best_amp !== 32'd60 || best_pass !== 4'd1) begin
      bad++; $display("FAIL early_result: got status=%b amp=%0d pass=%0d expected 001 60 1", status, best_amp, best_pass);
    end
    total++;
    if (fall_n - s_fall != 2) begin bad++; $display("FAIL early_passes: got %0d expected 2", fall_n - s_fall); end
  endtask

  task automatic test_timeout();
    int s_irq = irq_n, s_run = run_n;
    do_start(16'd10, 16'd20, 4'd1, 32'd100, 24'd100);
    wait_idle(200);
    total++;
    if (run_n - s_run != 100) begin bad++; $display("FAIL tmo_run_len: got %0d expected 100", run_n - s_run); end
    total++;
    if (status !== 3'b100 || irq_n - s_irq != 1) begin
      bad++; $display("FAIL tmo_status: got status=%b irqs=%0d expected 100 1", status, irq_n - s_irq);
    end
    total++;
    if (run !== 1'b0 || reset_max !== 1'b1 || dbg_state !== IDLE) begin
      bad++; $display("FAIL tmo_idle: run=%b rm=%b state=%0d expected 0 1 IDLE", run, reset_max, dbg_state);
    end
  endtask

  task automatic test_abort();
    int s_irq = irq_n;
    do_start(16'd10, 16'd20, 4'd1, 32'd100, '0);
    wait_run();
    repeat (20) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || run !== 1'b0 || reset_max !== 1'b1) begin
      bad++; $display("FAIL abort_idle: busy=%b run=%b rm=%b expected 0 0 1", busy, run, reset_max);
    end
    repeat (5) tick();
    total++;
    if (irq_n != s_irq || status !== 3'b000) begin
      bad++; $display("FAIL abort_no_irq: irqs=%0d status=%b expected 0 000", irq_n - s_irq, status);
    end
    do_start(16'd10, 16'd20, 4'd1, 32'd100, '0);
    do_pass(10, 32'd500, 32'd9, 16'd9);
    wait_idle(20);
    total++;
    if (status !== 3'b001 || best_amp !== 32'd500) begin
      bad++; $display("FAIL abort_restart: status=%b amp=%0d expected 001 500", status, best_amp);
    end
  endtask

  task automatic test_start_busy();
    do_start(16'd111, 16'd222, 4'd1, 32'd100, '0);
    wait_run();
    cfg_ntau = 16'h9999; cfg_nf = 16'h8888;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (ntau !== 16'd111 || nf !== 16'd222 || run !== 1'b1) begin
      bad++; $display("FAIL start_busy: ntau=%0d nf=%0d run=%b expected 111 222 1", ntau, nf, run);
    end
    do_pass(5, 32'd150, 32'd4, 16'd4);
    wait_idle(20);
  endtask

  task automatic test_done_idle();
    int s_irq = irq_n;
    done_max = 1'b1; amp_in = 32'd999;
    tick();
    done_max = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || status !== 3'b001 || best_amp !== 32'd150 || irq_n != s_irq) begin
      bad++; $display("FAIL done_idle: busy=%b status=%b amp=%0d irqs=%0d expected 0 001 150 0",
                      busy, status, best_amp, irq_n - s_irq);
    end
  endtask

  task automatic test_equal_amps();
    do_start(16'd10, 16'd20, 4'd2, 32'd1000, '0);
    do_pass(5, 32'd50, 32'd11, 16'd1);
    do_pass(5, 32'd50, 32'd22, 16'd2);
    wait_idle(30);
    total++;
    if (best_pass !== 4'd0 || best_tau !== 32'd11 || status !== 3'b010) begin
      bad++; $display("FAIL equal_amps: pass=%0d tau=%0d status=%b expected 0 11 010", best_pass, best_tau, status);
    end
  endtask

  task automatic test_npass_bounds();
    int s_fall = fall_n;
    do_start(16'd10, 16'd20, 4'd0, 32'd1000, '0);
    do_pass(5, 32'd10, 32'd1, 16'd1);
    wait_idle(30);
    total++;
    if (fall_n - s_fall != 1 || status !== 3'b010) begin
      bad++; $display("FAIL npass_zero: passes=%0d status=%b expected 1 010", fall_n - s_fall, status);
    end
    s_fall = fall_n;
    do_start(16'd10, 16'd20, 4'd15, 32'd1000, '0);
    for (int i = 0; i < 8; i++) do_pass(3, 32'(i * 10 + 5), 32'(i), 16'(i));
    wait_idle(30);
    total++;
    if (fall_n - s_fall != 8 || best_pass !== 4'd7 || best_amp !== 32'd75) begin
      bad++; $display("FAIL npass_sat: passes=%0d best_pass=%0d amp=%0d expected 8 7 75",
                      fall_n - s_fall, best_pass, best_amp);
    end
  endtask

  task automatic test_rst_mid_run();
    do_start(16'd77, 16'd88, 4'd1, 32'd100, '0);
    wait_run();
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({reset_max, run, busy, irq} !== 4'b1000 || status !== 3'b000 || best_amp !== 32'd0 ||
        ntau !== 16'd0 || nf !== 16'd0) begin
      bad++; $display("FAIL rst_mid_run: {rm,run,busy,irq}=%b status=%b amp=%0d ntau=%0d nf=%0d expected 1000 000 0 0 0",
                      {reset_max, run, busy, irq}, status, best_amp, ntau, nf);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_detect();
    test_multi_notfound();
    test_early_exit();
    test_timeout();
    test_abort();
    test_start_busy();
    test_done_idle();
    test_equal_amps();
    test_npass_bounds();
    test_rst_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
